// File: rtl/line_mem_pkg.sv
// Shared types and derived-geometry helpers for the line-organised backing memory.
// All helpers are constant functions so they can size ports and arrays.
package line_mem_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int line_w(input int word_w, input int line_words);
        return word_w * line_words;
    endfunction

    function automatic int line_bytes(input int word_w, input int line_words);
        return line_w(word_w, line_words) / 8;
    endfunction

    function automatic int offset_w(input int word_w, input int line_words);
        return clog2(line_bytes(word_w, line_words));
    endfunction

    function automatic int depth_lines(input int mem_kb, input int word_w, input int line_words);
        return (mem_kb * 1024) / line_bytes(word_w, line_words);
    endfunction

    function automatic int idx_w(input int mem_kb, input int word_w, input int line_words);
        return clog2(depth_lines(mem_kb, word_w, line_words));
    endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter: purely combinational, zero latency.
// Picks the first requester after ptr; no backpressure, en=0 forces no grant.
module mem_rr_arbiter
    import line_mem_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    logic found;
    int   c;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        if (en) begin
            // Scan starts one past the last winner so it gets lowest priority.
            for (int i = 1; i <= N; i++) begin
                c = (int'(ptr) + i) % N;
                if (!found && req[c]) begin
                    found  = 1'b1;
                    gnt[c] = 1'b1;
                    idx    = PW'(c);
                end
            end
        end
    end

endmodule

// File: rtl/line_memory_arb.sv
// Multi-channel line memory with byte enables behind a round-robin arbiter.
// Latency LATENCY cycles accept->done; one transaction in flight, gnt only while idle.
module line_memory_arb
    import line_mem_pkg::*;
#(
    parameter int    NUM_CH     = 2,
    parameter int    WORD_W     = 32,
    parameter int    LINE_WORDS = 4,
    parameter int    MEM_KB     = 32,
    parameter int    LATENCY    = 4,
    parameter string INIT_FILE  = ""
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic [NUM_CH-1:0]                                   req,
    input  logic [NUM_CH-1:0]                                   we,
    input  logic [NUM_CH*32-1:0]                                addr,
    input  logic [NUM_CH*line_w(WORD_W, LINE_WORDS)-1:0]        wdata,
    input  logic [NUM_CH*line_bytes(WORD_W, LINE_WORDS)-1:0]    wbe,
    output logic [NUM_CH-1:0]                                   gnt,
    output logic [NUM_CH-1:0]                                   done,
    output logic [line_w(WORD_W, LINE_WORDS)-1:0]               rdata
);

    localparam int LW    = line_w(WORD_W, LINE_WORDS);
    localparam int LB    = line_bytes(WORD_W, LINE_WORDS);
    localparam int OFF_W = offset_w(WORD_W, LINE_WORDS);
    localparam int DEPTH = depth_lines(MEM_KB, WORD_W, LINE_WORDS);
    localparam int IDX_W = idx_w(MEM_KB, WORD_W, LINE_WORDS);
    localparam int WB    = WORD_W / 8;
    localparam int PW    = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
    localparam int CNT_W = (LATENCY > 1) ? clog2(LATENCY + 1) : 1;
    localparam int WORDS = DEPTH * LINE_WORDS;
    localparam int WA_W  = clog2(WORDS);

    initial begin
        if (LATENCY < 1)
            $error("line_memory_arb: LATENCY must be >= 1");
        if (LINE_WORDS < 1 || (LINE_WORDS & (LINE_WORDS - 1)) != 0)
            $error("line_memory_arb: LINE_WORDS must be a power of 2");
    end

    logic [WORD_W-1:0] mem [WORDS];

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = '0;
    end

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [PW-1:0]     ptr, sel_q, arb_idx;
    logic [NUM_CH-1:0] arb_gnt;
    logic              arb_en, we_q;
    logic [IDX_W-1:0]  idx_q;
    logic [LW-1:0]     wdata_q;
    logic [LB-1:0]     wbe_q;

    function automatic logic [WA_W-1:0] waddr(input logic [IDX_W-1:0] li, input int k);
        return WA_W'(int'(li) * LINE_WORDS + k);
    endfunction

    mem_rr_arbiter #(.N(NUM_CH), .PW(PW)) u_arb (
        .req (req),
        .ptr (ptr),
        .en  (arb_en),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign gnt = arb_gnt;

    always_comb begin
        state_nxt = state;
        // Reset gates the grant so nothing is offered while the block is held.
        arb_en    = (state == IDLE) && rst_n;
        case (state)
            IDLE:    if (|req) state_nxt = (LATENCY == 1) ? DONE : ACCESS;
            ACCESS:  if (cnt <= CNT_W'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ptr     <= PW'(NUM_CH - 1);
            sel_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            wbe_q   <= '0;
            done    <= '0;
            rdata   <= '0;
        end else begin
            state <= state_nxt;
            done  <= '0;
            if (|arb_gnt) begin
                sel_q   <= arb_idx;
                ptr     <= arb_idx;
                we_q    <= we[arb_idx];
                idx_q   <= addr[int'(arb_idx)*32 + OFF_W +: IDX_W];
                wdata_q <= wdata[int'(arb_idx)*LW +: LW];
                wbe_q   <= wbe[int'(arb_idx)*LB +: LB];
                cnt     <= CNT_W'(LATENCY - 1);
            end else if (state == ACCESS) begin
                cnt <= cnt - CNT_W'(1);
            end
            // The array is touched on the same edge that raises done, so a
            // reset at any earlier point leaves it and rdata untouched.
            if (state == DONE) begin
                done[sel_q] <= 1'b1;
                if (!we_q) begin
                    for (int k = 0; k < LINE_WORDS; k++)
                        rdata[k*WORD_W +: WORD_W] <= mem[waddr(idx_q, k)];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == DONE && we_q) begin
            for (int k = 0; k < LINE_WORDS; k++)
                for (int b = 0; b < WB; b++)
                    if (wbe_q[k*WB + b])
                        mem[waddr(idx_q, k)][b*8 +: 8] <= wdata_q[(k*WB + b)*8 +: 8];
        end
    end

endmodule
